// File: rtl/demux_sched_if.sv
// Bundle of the upstream handshake, the four-channel downstream side and
// the status/debug outputs of demux_sched.
//
// Handshake rule for both sides: a word moves on a rising clk edge exactly
// when valid and ready are both 1 on that edge. Valid never depends on
// ready; ready may depend combinationally on valid-side state.
interface demux_sched_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         mode;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   out_ready;
  logic         busy;
  logic [7:0]   xfer_cnt;
  logic         dbg_state;
  logic [1:0]   dbg_rr_ptr;

  // Upstream producer / downstream consumer side (the testbench).
  modport master (
    output in_valid, in_data, mode, in_sel, out_ready,
    input  in_ready, out_valid, out_data, busy, xfer_cnt, dbg_state, dbg_rr_ptr
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, in_data, mode, in_sel, out_ready,
    output in_ready, out_valid, out_data, busy, xfer_cnt, dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/demux_sched.sv
// One-word holding demultiplexer: each accepted word is routed to one of
// four channels, either round-robin (mode=0) or explicitly (mode=1).
// Ready is bypassed from the downstream channel so a word can be accepted
// on the same edge the held one completes, giving one word per cycle.
module demux_sched #(
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst_n,
  demux_sched_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [1:0]   dest_q, dest_d;
  logic         rr_route_q, rr_route_d;
  logic [1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0] hold_q, hold_d;
  logic [7:0]   xfer_q, xfer_d;
  logic         complete;
  logic         accept;
  logic         in_ready;

  // Completion only looks at the ready bit of the latched destination.
  always_comb begin
    complete = (state_q == S_HOLD) && bus.out_ready[dest_q];
    in_ready = rst_n && ((state_q == S_IDLE) || complete);
    accept   = bus.in_valid && in_ready;
  end

  // Next-state logic; completion is applied first so that a word accepted
  // on the same edge sees the already-advanced round-robin pointer.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    rr_route_d = rr_route_q;
    rr_ptr_d   = rr_ptr_q;
    hold_d     = hold_q;
    xfer_d     = xfer_q;
    if (complete) begin
      state_d = S_IDLE;
      xfer_d  = xfer_q + 8'd1;
      if (rr_route_q) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end
    if (accept) begin
      state_d    = S_HOLD;
      hold_d     = bus.in_data;
      rr_route_d = !bus.mode;
      dest_d     = bus.mode ? bus.in_sel : rr_ptr_d;
    end
  end

  // State registers; reset discards any held word without counting it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dest_q     <= 2'd0;
      rr_route_q <= 1'b0;
      rr_ptr_q   <= 2'd0;
      hold_q     <= '0;
      xfer_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      rr_route_q <= rr_route_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      xfer_q     <= xfer_d;
    end
  end

  // Outputs; valid/busy are also masked while reset is held low.
  always_comb begin
    bus.in_ready   = in_ready;
    bus.out_valid  = (rst_n && state_q == S_HOLD) ? (4'b0001 << dest_q) : 4'b0000;
    bus.out_data   = hold_q;
    bus.busy       = rst_n && (state_q == S_HOLD);
    bus.xfer_cnt   = xfer_q;
    bus.dbg_state  = state_q[0];
    bus.dbg_rr_ptr = rr_ptr_q;
  end
endmodule

// File: tb/tb_demux_sched.sv
// Directed testbench for demux_sched.
module tb_demux_sched;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  logic [W-1:0] exp_q[$];
  logic [1:0]   rr_m;
  logic [7:0]   xfer_m;

  demux_sched_if #(.W(W)) bus ();

  demux_sched #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge; sampling point is 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic drive_in(input logic v, input logic [W-1:0] d, input logic m, input logic [1:0] s);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.mode     = m;
    bus.in_sel   = s;
  endtask

  // back-to-back round-robin burst of n words with all channels ready
  task automatic rr_burst(input int n, input logic [W-1:0] base, input string tag);
    logic [W-1:0] w;
    bus.out_ready = 4'b1111;
    w = base;
    exp_q.push_back(w);
    drive_in(1'b1, w, 1'b0, 2'd0);
    step();
    for (int i = 1; i <= n; i++) begin
      check({tag, "_valid"}, 32'(bus.out_valid), 32'(4'b0001 << rr_m));
      check({tag, "_data"}, 32'(bus.out_data), 32'(exp_q.pop_front()));
      if (i < n) begin
        w = base + W'(i * 3 + 1);
        exp_q.push_back(w);
        drive_in(1'b1, w, 1'b0, 2'd0);
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      end else begin
        drive_in(1'b0, 8'h00, 1'b0, 2'd0);
      end
      step();
      rr_m   = rr_m + 2'd1;
      xfer_m = xfer_m + 8'd1;
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rr_m    = 2'd0;
    xfer_m  = 8'd0;
    rst_n   = 1'b0;
    bus.out_ready = 4'b1111;
    drive_in(1'b1, 8'h5A, 1'b0, 2'd0);
    #1;
    repeat (3) step();

    // reset state, including ready gated by reset
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_xfer", 32'(bus.xfer_cnt), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);

    // round-robin burst 11,22,33,44, accepted on the first edge out of reset
    rst_n = 1'b1;
    bus.out_ready = 4'b1111;
    exp_q.push_back(8'h11);
    drive_in(1'b1, 8'h11, 1'b0, 2'd0);
    #1;
    check("rr_in_ready0", 32'(bus.in_ready), 32'd1);
    step();
    check("rr_v0", 32'(bus.out_valid), 32'b0001);
    check("rr_d0", 32'(bus.out_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h22);
    drive_in(1'b1, 8'h22, 1'b0, 2'd0);
    #1;
    check("rr_in_ready1", 32'(bus.in_ready), 32'd1);
    step();
    check("rr_v1", 32'(bus.out_valid), 32'b0010);
    check("rr_d1", 32'(bus.out_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h33);
    drive_in(1'b1, 8'h33, 1'b0, 2'd0);
    #1;
    check("rr_in_ready2", 32'(bus.in_ready), 32'd1);
    step();
    check("rr_v2", 32'(bus.out_valid), 32'b0100);
    check("rr_d2", 32'(bus.out_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h44);
    drive_in(1'b1, 8'h44, 1'b0, 2'd0);
    #1;
    check("rr_in_ready3", 32'(bus.in_ready), 32'd1);
    step();
    check("rr_v3", 32'(bus.out_valid), 32'b1000);
    check("rr_d3", 32'(bus.out_data), 32'(exp_q.pop_front()));
    drive_in(1'b0, 8'h00, 1'b0, 2'd0);
    step();
    check("rr_xfer4", 32'(bus.xfer_cnt), 32'd4);
    check("rr_idle", 32'(bus.busy), 32'd0);
    check("rr_idle_valid", 32'(bus.out_valid), 32'd0);
    check("rr_idle_data_kept", 32'(bus.out_data), 32'h44);
    // fifth word wraps back to channel 0
    drive_in(1'b1, 8'h55, 1'b0, 2'd0);
    step();
    check("rr_v4_wrap", 32'(bus.out_valid), 32'b0001);
    drive_in(1'b0, 8'h00, 1'b0, 2'd0);
    step();
    check("rr_xfer5", 32'(bus.xfer_cnt), 32'd5);
    check("rr_ptr1", 32'(bus.dbg_rr_ptr), 32'd1);

    // mode switch while held: dest stays at rr channel 1
    bus.out_ready = 4'b0000;
    drive_in(1'b1, 8'h66, 1'b0, 2'd0);
    step();
    drive_in(1'b0, 8'h00, 1'b1, 2'd3);
    #1;
    check("ms_valid", 32'(bus.out_valid), 32'b0010);
    bus.out_ready = 4'b1000;
    step();
    check("ms_still_held", 32'(bus.busy), 32'd1);
    check("ms_xfer_hold", 32'(bus.xfer_cnt), 32'd5);
    bus.out_ready = 4'b0010;
    step();
    check("ms_done", 32'(bus.busy), 32'd0);
    check("ms_rr_ptr2", 32'(bus.dbg_rr_ptr), 32'd2);
    check("ms_xfer6", 32'(bus.xfer_cnt), 32'd6);

    // explicit routing to channel 2 with a 3-cycle stall
    bus.out_ready = 4'b0000;
    drive_in(1'b1, 8'hA5, 1'b1, 2'd2);
    step();
    drive_in(1'b0, 8'h00, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ex_valid", 32'(bus.out_valid), 32'b0100);
      check("ex_busy", 32'(bus.busy), 32'd1);
      check("ex_in_ready0", 32'(bus.in_ready), 32'd0);
      check("ex_data", 32'(bus.out_data), 32'hA5);
      step();
    end
    bus.out_ready = 4'b0100;
    #1;
    check("ex_valid4", 32'(bus.out_valid), 32'b0100);
    check("ex_in_ready1", 32'(bus.in_ready), 32'd1);
    step();
    check("ex_done", 32'(bus.busy), 32'd0);
    check("ex_rr_same", 32'(bus.dbg_rr_ptr), 32'd2);
    check("ex_xfer7", 32'(bus.xfer_cnt), 32'd7);

    // wrong-channel ready ignored
    bus.out_ready = 4'b0000;
    drive_in(1'b1, 8'h3C, 1'b1, 2'd1);
    step();
    drive_in(1'b0, 8'h00, 1'b1, 2'd1);
    bus.out_ready = 4'b1101;
    #1;
    check("wc_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("wc_held", 32'(bus.busy), 32'd1);
    check("wc_valid", 32'(bus.out_valid), 32'b0010);
    check("wc_xfer", 32'(bus.xfer_cnt), 32'd7);
    bus.out_ready = 4'b0010;
    step();
    check("wc_done", 32'(bus.busy), 32'd0);
    check("wc_xfer8", 32'(bus.xfer_cnt), 32'd8);

    // completion and accept on the same edge
    bus.out_ready = 4'b0000;
    drive_in(1'b1, 8'h77, 1'b1, 2'd0);
    step();
    drive_in(1'b1, 8'h88, 1'b1, 2'd3);
    bus.out_ready = 4'b0001;
    #1;
    check("sa_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("sa_valid", 32'(bus.out_valid), 32'b1000);
    check("sa_data", 32'(bus.out_data), 32'h88);
    check("sa_busy", 32'(bus.busy), 32'd1);
    check("sa_xfer9", 32'(bus.xfer_cnt), 32'd9);
    drive_in(1'b0, 8'h00, 1'b1, 2'd0);
    bus.out_ready = 4'b1000;
    step();
    check("sa_xfer10", 32'(bus.xfer_cnt), 32'd10);

    // reset mid-hold: bring rr to 3, hold a word for channel 3, then reset
    bus.out_ready = 4'b1111;
    drive_in(1'b1, 8'h12, 1'b0, 2'd0);
    step();
    check("rh_ch2", 32'(bus.out_valid), 32'b0100);
    bus.out_ready = 4'b0100;
    drive_in(1'b1, 8'h99, 1'b0, 2'd0);
    step();
    drive_in(1'b0, 8'h00, 1'b0, 2'd0);
    bus.out_ready = 4'b0000;
    #1;
    check("rh_held_ch3", 32'(bus.out_valid), 32'b1000);
    check("rh_xfer11", 32'(bus.xfer_cnt), 32'd11);
    rst_n = 1'b0;
    step();
    check("rh_valid", 32'(bus.out_valid), 32'd0);
    check("rh_xfer", 32'(bus.xfer_cnt), 32'd0);
    check("rh_data", 32'(bus.out_data), 32'h00);
    check("rh_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 4'b1111;
    drive_in(1'b1, 8'hAB, 1'b0, 2'd0);
    step();
    check("rh_next_ch0", 32'(bus.out_valid), 32'b0001);
    drive_in(1'b0, 8'h00, 1'b0, 2'd0);
    step();
    check("rh_xfer1", 32'(bus.xfer_cnt), 32'd1);
    rr_m   = 2'd1;
    xfer_m = 8'd1;

    // counter wrap: 255 more round-robin words make 256 completions
    rr_burst(255, 8'h20, "wrap");
    check("wrap_xfer0", 32'(bus.xfer_cnt), 32'(xfer_m));
    check("wrap_xfer_is0", 32'(bus.xfer_cnt), 32'd0);
    check("wrap_rr0", 32'(bus.dbg_rr_ptr), 32'd0);
    check("wrap_idle", 32'(bus.busy), 32'd0);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
